// File: rtl/operand_rr_arbiter.sv
`default_nettype none
// ============================================================================
// operand_rr_arbiter : round-robin share of one operand sink among NUM_REQ
//                      valid/ready sources, with a per-port protocol monitor.
// Revision 1.0
// ============================================================================
module operand_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int SRC_W   = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_operand_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      m_valid_o,
  output logic [DATA_W-1:0]         m_operand_o,
  output logic [SRC_W-1:0]          m_src_o,
  input  logic                      m_ready_i,
  output logic [NUM_REQ-1:0]        proto_err_o,
  output logic [15:0]               hs_count_o
);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  operand_q, operand_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [SRC_W-1:0]   ptr_q, ptr_d;
  logic [15:0]        hs_q, hs_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic [DATA_W-1:0]  op_arr    [NUM_REQ];
  logic [DATA_W-1:0]  op_copy_q [NUM_REQ];

  logic               load;
  logic               grant_vld;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W:0]     idx_sum;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign op_arr[gi] = req_operand_i[gi*DATA_W +: DATA_W];
  end

  assign load = (state_q == S_EMPTY) || m_ready_i;

  // Rotating priority search starting at ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx_sum   = '0;
    if (load) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx_sum = {1'b0, ptr_q} + (SRC_W+1)'(k);
        if (idx_sum >= (SRC_W+1)'(NUM_REQ)) begin
          idx_sum = idx_sum - (SRC_W+1)'(NUM_REQ);
        end
        if (!grant_vld && req_valid_i[idx_sum[SRC_W-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = idx_sum[SRC_W-1:0];
        end
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (grant_vld) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    src_d     = src_q;
    ptr_d     = ptr_q;
    if (load) begin
      if (grant_vld) begin
        state_d   = S_FULL;
        operand_d = op_arr[grant_idx];
        src_d     = grant_idx;
        ptr_d     = (grant_idx == SRC_W'(NUM_REQ-1)) ? '0 : grant_idx + SRC_W'(1);
      end else begin
        state_d   = S_EMPTY;
      end
    end
  end

  always_comb begin
    hs_d = hs_q;
    if ((state_q == S_FULL) && m_ready_i && (hs_q != 16'hFFFF)) begin
      hs_d = hs_q + 16'd1;
    end
  end

  // A stalled source must keep valid high and its operand stable.
  always_comb begin
    pend_d = '0;
    err_d  = err_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_d[i] = req_valid_i[i] && !req_ready_o[i];
      if (pend_q[i] && (!req_valid_i[i] || (op_arr[i] != op_copy_q[i]))) begin
        err_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_EMPTY;
      operand_q <= '0;
      src_q     <= '0;
      ptr_q     <= '0;
      hs_q      <= '0;
      pend_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      src_q     <= src_d;
      ptr_q     <= ptr_d;
      hs_q      <= hs_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        op_copy_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        op_copy_q[i] <= op_arr[i];
      end
    end
  end

  assign m_valid_o   = (state_q == S_FULL);
  assign m_operand_o = operand_q;
  assign m_src_o     = src_q;
  assign proto_err_o = err_q;
  assign hs_count_o  = hs_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_operand_rr_arbiter : directed self-checking bench for operand_rr_arbiter
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_operand_rr_arbiter;

  logic        clk;
  logic        rstn;
  logic [3:0]  req_valid;
  logic [7:0]  ops [4];
  logic [31:0] req_operand;
  logic [3:0]  req_ready;
  logic        m_valid;
  logic [7:0]  m_operand;
  logic [1:0]  m_src;
  logic        m_ready;
  logic [3:0]  proto_err;
  logic [15:0] hs_count;

  int n_checks = 0;
  int n_fail   = 0;

  assign req_operand = {ops[3], ops[2], ops[1], ops[0]};

  operand_rr_arbiter #(.NUM_REQ(4), .DATA_W(8), .SRC_W(2)) u_dut (
    .clk           (clk),
    .rstn          (rstn),
    .req_valid_i   (req_valid),
    .req_operand_i (req_operand),
    .req_ready_o   (req_ready),
    .m_valid_o     (m_valid),
    .m_operand_o   (m_operand),
    .m_src_o       (m_src),
    .m_ready_i     (m_ready),
    .proto_err_o   (proto_err),
    .hs_count_o    (hs_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  task automatic clear_inputs;
    req_valid = '0;
    m_ready   = 1'b0;
    for (int i = 0; i < 4; i++) ops[i] = '0;
  endtask

  task automatic do_reset;
    rstn = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    clear_inputs();

    // Reset state
    at_neg();
    check("rst_m_valid", 32'(m_valid), 32'h0);
    check("rst_m_operand", 32'(m_operand), 32'h0);
    check("rst_m_src", 32'(m_src), 32'h0);
    check("rst_proto_err", 32'(proto_err), 32'h0);
    check("rst_hs_count", 32'(hs_count), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Single requester
    ops[2] = 8'hA5; req_valid = 4'b0100; m_ready = 1'b1;
    at_neg();
    check("single_req_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = 4'b0000;
    at_neg();
    check("single_m_valid", 32'(m_valid), 32'h1);
    check("single_m_operand", 32'(m_operand), 32'hA5);
    check("single_m_src", 32'(m_src), 32'h2);
    check("single_hs_before", 32'(hs_count), 32'h0);
    check("single_ready_after", 32'(req_ready), 32'h0);
    step();
    at_neg();
    check("single_hs_after", 32'(hs_count), 32'h1);
    check("single_drain", 32'(m_valid), 32'h0);

    // All four requesters continuously valid
    do_reset();
    ops[0] = 8'h10; ops[1] = 8'h11; ops[2] = 8'h12; ops[3] = 8'h13;
    req_valid = 4'b1111; m_ready = 1'b1;
    at_neg();
    check("rr_first_ready", 32'(req_ready), 32'h1);
    for (int k = 0; k < 6; k++) begin
      step();
      at_neg();
      check($sformatf("rr_src_%0d", k), 32'(m_src), 32'(k % 4));
      check($sformatf("rr_op_%0d", k), 32'(m_operand), 32'(8'h10 + k % 4));
    end
    check("rr_proto_err", 32'(proto_err), 32'h0);

    // Backpressure
    do_reset();
    ops[0] = 8'h55; req_valid = 4'b0001; m_ready = 1'b1;
    step();
    m_ready = 1'b0; req_valid = 4'b1111;
    ops[1] = 8'h21; ops[2] = 8'h22; ops[3] = 8'h23;
    for (int k = 0; k < 5; k++) begin
      at_neg();
      check($sformatf("bp_op_%0d", k), 32'(m_operand), 32'h55);
      check($sformatf("bp_ready_%0d", k), 32'(req_ready), 32'h0);
      step();
    end
    at_neg();
    check("bp_proto_err", 32'(proto_err), 32'h0);
    check("bp_hs_count", 32'(hs_count), 32'h0);
    m_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'h2);
    step();
    at_neg();
    check("bp_next_src", 32'(m_src), 32'h1);
    check("bp_next_op", 32'(m_operand), 32'h21);
    check("bp_hs_after", 32'(hs_count), 32'h1);

    // Protocol violation: valid dropped while pending
    do_reset();
    ops[0] = 8'h77; req_valid = 4'b0001; m_ready = 1'b1;
    step();
    m_ready = 1'b0; req_valid = 4'b0010; ops[1] = 8'h31;
    at_neg();
    check("pv_ready_blocked", 32'(req_ready), 32'h0);
    step();
    req_valid = 4'b0000;
    at_neg();
    check("pv_not_yet", 32'(proto_err), 32'h0);
    step();
    at_neg();
    check("pv_drop_err", 32'(proto_err), 32'h2);
    m_ready = 1'b1;
    repeat (3) step();
    check("pv_sticky", 32'(proto_err), 32'h2);
    do_reset();
    check("pv_reset_clear", 32'(proto_err), 32'h0);

    // Protocol violation: operand changed while pending
    ops[0] = 8'h77; req_valid = 4'b0001; m_ready = 1'b1;
    step();
    m_ready = 1'b0; req_valid = 4'b1000; ops[3] = 8'h40;
    step();
    ops[3] = 8'h41;
    step();
    at_neg();
    check("pv_op_err", 32'(proto_err), 32'h8);
    check("pv_op_hold", 32'(m_operand), 32'h77);

    // Asynchronous reset while FULL
    do_reset();
    ops[0] = 8'h66; req_valid = 4'b0001; m_ready = 1'b1;
    step();
    step();
    at_neg();
    check("ar_pre_hs", 32'(hs_count), 32'h1);
    check("ar_pre_valid", 32'(m_valid), 32'h1);
    rstn = 1'b0;
    #1;
    check("ar_m_valid", 32'(m_valid), 32'h0);
    check("ar_hs_count", 32'(hs_count), 32'h0);
    check("ar_m_operand", 32'(m_operand), 32'h0);
    req_valid = 4'b1000; ops[3] = 8'h99; m_ready = 1'b1;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    at_neg();
    check("ar_post_ready", 32'(req_ready), 32'h8);
    step();
    at_neg();
    check("ar_post_src", 32'(m_src), 32'h3);
    check("ar_post_op", 32'(m_operand), 32'h99);

    // Handshake counter saturation
    do_reset();
    ops[0] = 8'h01; req_valid = 4'b0001; m_ready = 1'b1;
    for (int n = 1; n <= 70000; n++) begin
      step();
      if (n == 1000)  check("sat_mid", 32'(hs_count), 32'd999);
      if (n == 65535) check("sat_near", 32'(hs_count), 32'hFFFE);
      if (n == 65536) check("sat_hit", 32'(hs_count), 32'hFFFF);
    end
    check("sat_final", 32'(hs_count), 32'hFFFF);
    check("sat_proto_err", 32'(proto_err), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
